// File: rtl/age_arbiter.sv
// Age-based single-owner arbiter: the longest-waiting requester wins the
// resource, keeps it until it signals done or its hold budget runs out.
module age_arbiter #(
  parameter int REQ_COUNT = 4,
  parameter int AGE_WIDTH = 4,
  parameter int TIMEOUT   = 64,
  parameter int IDX_WIDTH = $clog2(REQ_COUNT)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [REQ_COUNT-1:0] i_req,
  input  logic                 i_done,
  output logic [REQ_COUNT-1:0] o_gnt,
  output logic [IDX_WIDTH-1:0] o_gnt_idx,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int HOLD_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [AGE_WIDTH-1:0]   age [REQ_COUNT];
  logic [HOLD_WIDTH-1:0]  hold;
  logic [HOLD_WIDTH-1:0]  hold_next;
  logic [REQ_COUNT-1:0]   gnt_next;
  logic [IDX_WIDTH-1:0]   idx_next;
  logic                   busy_next;
  logic                   timeout_next;
  logic                   grant_now;
  logic                   timeout_hit;

  logic [IDX_WIDTH-1:0]   winner;
  logic [AGE_WIDTH-1:0]   best_age;
  logic                   any_req;

  // Strict '>' while scanning upward keeps ties with the lowest index.
  always_comb begin
    winner   = '0;
    best_age = '0;
    any_req  = 1'b0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      if (i_req[k] && (!any_req || age[k] > best_age)) begin
        winner   = IDX_WIDTH'(k);
        best_age = age[k];
        any_req  = 1'b1;
      end
    end
  end

  assign timeout_hit = TIMEOUT_EN && (hold == HOLD_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_next   = state;
    gnt_next     = o_gnt;
    idx_next     = o_gnt_idx;
    busy_next    = o_busy;
    timeout_next = 1'b0;
    hold_next    = hold;
    grant_now    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = BUSY;
          gnt_next   = REQ_COUNT'(1) << winner;
          idx_next   = winner;
          busy_next  = 1'b1;
          hold_next  = '0;
          grant_now  = 1'b1;
        end
      end
      BUSY: begin
        if (i_done || timeout_hit) begin
          state_next   = IDLE;
          gnt_next     = '0;
          busy_next    = 1'b0;
          timeout_next = !i_done;
        end else begin
          hold_next = hold + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      hold      <= '0;
      o_gnt     <= '0;
      o_gnt_idx <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      hold      <= hold_next;
      o_gnt     <= gnt_next;
      o_gnt_idx <= idx_next;
      o_busy    <= busy_next;
      o_timeout <= timeout_next;
    end
  end

  // The owner's age is pinned at zero, which also covers a timed-out owner.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < REQ_COUNT; k++) begin
      if (i_reset || !i_req[k] ||
          (grant_now && winner == IDX_WIDTH'(k)) ||
          (o_busy && o_gnt_idx == IDX_WIDTH'(k))) begin
        age[k] <= '0;
      end else if (age[k] != AGE_MAX) begin
        age[k] <= age[k] + 1'b1;
      end
    end
  end

endmodule
